// File: rtl/lsu_mem_initiator_pkg.sv
// Shared types and encodings for the LSU memory initiator.
// Holds the FSM state enum, access-size codes, the timeout default and the latched request struct.
package lsu_mem_initiator_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    localparam int TIMEOUT_DEF = 255;

    typedef struct packed {
        logic        wen;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  size;
        logic        uns;
    } req_t;

    // Size 3 is never legal; halves need an even address, words a 4-byte aligned one.
    function automatic logic is_bad(input logic [1:0] size, input logic [1:0] off);
        case (size)
            SZ_B:    return 1'b0;
            SZ_H:    return off[0];
            SZ_W:    return off != 2'd0;
            default: return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Combinational load extraction: shift the addressed lane down, truncate to the
// access size, then sign- or zero-extend to 32 bits.
module lsu_load_align
    import lsu_mem_initiator_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  off,
    input  logic [1:0]  size,
    input  logic        uns,
    output logic [31:0] data
);

    logic [31:0] shifted;

    always_comb begin
        shifted = rdata >> {off, 3'b000};
        case (size)
            SZ_B:    data = {{24{~uns & shifted[7]}},  shifted[7:0]};
            SZ_H:    data = {{16{~uns & shifted[15]}}, shifted[15:0]};
            default: data = shifted;
        endcase
    end

endmodule

// File: rtl/lsu_mem_initiator.sv
// Single-outstanding load/store initiator: accepts one request, drives a word-aligned
// memory access with byte lanes, waits for completion (bounded by TIMEOUT) and returns a response.
module lsu_mem_initiator
    import lsu_mem_initiator_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wen,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        mem_ren,
    output logic        mem_wen,
    output logic [7:0]  mem_wmask,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_valid
);

    state_t      state, state_nxt;
    req_t        rq;
    logic [7:0]  cnt;
    logic [31:0] rdata_q;
    logic        err_q;
    logic [31:0] ld_data;
    logic [3:0]  mask;
    logic        bad;
    logic        tmo;

    assign bad = is_bad(req_size, req_addr[1:0]);
    // Expiry fires on the waiting cycle that would bring the count up to TIMEOUT.
    assign tmo = !mem_valid && (cnt == 8'(TIMEOUT - 1));

    lsu_load_align u_align (
        .rdata (mem_rdata),
        .off   (rq.addr[1:0]),
        .size  (rq.size),
        .uns   (rq.uns),
        .data  (ld_data)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:           if (req_valid) state_nxt = bad ? ST_RESP : (req_wen ? ST_WRITE : ST_READ);
            ST_READ, ST_WRITE: if (mem_valid || tmo) state_nxt = ST_RESP;
            ST_RESP:           if (rsp_ready) state_nxt = ST_IDLE;
            default:           state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        mask = 4'b1111;
        case (rq.size)
            SZ_B:    mask = 4'b0001 << rq.addr[1:0];
            SZ_H:    mask = 4'b0011 << rq.addr[1:0];
            default: mask = 4'b1111;
        endcase
        req_ready = (state == ST_IDLE);
        rsp_valid = (state == ST_RESP);
        rsp_rdata = rdata_q;
        rsp_err   = err_q;
        mem_ren   = (state == ST_READ)  & ~rq.wen;
        mem_wen   = (state == ST_WRITE) &  rq.wen;
        mem_wmask = (state == ST_WRITE) ? {4'b0000, mask} : 8'h00;
        mem_addr  = {rq.addr[31:2], 2'b00};
        mem_wdata = rq.wdata << {rq.addr[1:0], 3'b000};
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= ST_IDLE;
            rq      <= '0;
            cnt     <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        rq      <= '{wen: req_wen, addr: req_addr, wdata: req_wdata,
                                     size: req_size, uns: req_unsigned};
                        cnt     <= '0;
                        rdata_q <= '0;
                        err_q   <= bad;
                    end
                end
                ST_READ, ST_WRITE: begin
                    if (mem_valid) begin
                        if (state == ST_READ) rdata_q <= ld_data;
                    end else if (tmo) begin
                        err_q   <= 1'b1;
                        rdata_q <= '0;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
